fetch_queue: RTL

Parametrised instruction-fetch stage for the MIPS core. It replaces the bare pc register and the PC+4 adder with a PC sequencer that streams requests to instruction memory and buffers the returned words in a DEPTH-entry prefetch queue. Decode consumes entries through a valid/ready handshake. Branch, jump and jr targets computed downstream arrive on a redirect port, which flushes the queue and squashes any in-flight fetch.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_queue_pkg;

  localparam logic [1:0]  ALIGN_MASK = 2'b11;
  localparam int unsigned PC_INC     = 4;

  // Width needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: register array, head visible combinationally from the read pointer.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int OCC_W = occ_width(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [OCC_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == OCC_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign count = count_reg;
  assign rdata = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + OCC_W'(1);
        2'b01:   count_reg <= count_reg - OCC_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC sequencer, single-outstanding imem request, prefetch queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int                ADDR_W   = 32,
  parameter  int                DATA_W   = 32,
  parameter  int                DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int                OCC_W    = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc4,
  output logic [OCC_W-1:0]  occupancy,
  output logic              fetch_misalign
);

  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]        fetch_pc_reg;
  logic [ADDR_W-1:0]        pending_pc_reg;
  logic                     inflight_reg;
  logic                     misalign_reg;
  logic [OCC_W:0]           committed;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [DATA_W+ADDR_W-1:0] head;

  // Queued entries plus the outstanding response must fit; a same-cycle pop does not count.
  assign committed = {1'b0, occupancy} + (OCC_W + 1)'(inflight_reg);
  assign imem_req  = reset && !redirect_valid && (committed < DEPTH_L);
  assign imem_addr = fetch_pc_reg;

  assign push = inflight_reg && !redirect_valid && !full;
  assign pop  = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg   <= RESET_PC;
      pending_pc_reg <= RESET_PC;
      inflight_reg   <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      misalign_reg <= redirect_valid && |(redirect_pc[1:0] & ALIGN_MASK);
      if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc & ~ADDR_W'(ALIGN_MASK);
        inflight_reg <= 1'b0;
      end else if (imem_req) begin
        pending_pc_reg <= fetch_pc_reg;
        fetch_pc_reg   <= fetch_pc_reg + ADDR_W'(PC_INC);
        inflight_reg   <= 1'b1;
      end else begin
        inflight_reg <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, pending_pc_reg}),
    .rdata (head),
    .count (occupancy),
    .full  (full),
    .empty (empty)
  );

  assign instr_valid    = !empty;
  assign instr_out      = head[ADDR_W +: DATA_W];
  assign instr_pc       = head[ADDR_W-1:0];
  assign instr_pc4      = instr_pc + ADDR_W'(PC_INC);
  assign fetch_misalign = misalign_reg;

endmodule
